// File: rtl/sar_adc_pkg.sv
// sar_adc_pkg: shared FSM states, default timing and helpers for the SAR sequencer
package sar_adc_pkg;
  typedef enum logic [2:0] {S_IDLE, S_RST, S_GAP_A, S_SMPL, S_GAP_H, S_CONV, S_DONE} state_e;
  localparam int DEF_N_CHNL   = 14;
  localparam int DEF_DAC_W    = 10;
  localparam int DEF_T_RST    = 4;
  localparam int DEF_T_GAP    = 1;
  localparam int DEF_T_SMPL   = 8;
  localparam int DEF_T_SETTLE = 3;
  localparam int TMR_W        = 8;
  function automatic logic [7:0] onehot2idx(input logic [63:0] oh);
    onehot2idx = '0;
    for (int i = 0; i < 64; i++) if (oh[i]) onehot2idx = 8'(i);
  endfunction
endpackage

// File: rtl/sar_adc_tmr.sv
// sar_adc_tmr: loadable down-counter; done_o marks the last cycle of a timed interval
module sar_adc_tmr import sar_adc_pkg::*; #(
  parameter int W = TMR_W
) (
  input  logic         clk,
  input  logic         srstz,
  input  logic         ld_i,
  input  logic [W-1:0] val_i,
  output logic         done_o
);
  logic [W-1:0] cnt_q;
  // The load cycle is itself the first cycle of the interval, hence val-2 here.
  always_ff @(posedge clk or negedge srstz)
    if (!srstz) cnt_q <= '0;
    else if (ld_i) cnt_q <= (val_i > W'(1)) ? val_i - W'(2) : '0;
    else if (cnt_q != '0) cnt_q <= cnt_q - W'(1);
  assign done_o = ld_i ? (val_i <= W'(1)) : (cnt_q == '0);
endmodule

// File: rtl/sar_adc_seq.sv
// sar_adc_seq: multi-channel SAR sequencer driving the S/H, channel mux and DAC of the analog macro
module sar_adc_seq import sar_adc_pkg::*; #(
  parameter  int N_CHNL   = DEF_N_CHNL,
  parameter  int DAC_W    = DEF_DAC_W,
  parameter  int T_RST    = DEF_T_RST,
  parameter  int T_GAP    = DEF_T_GAP,
  parameter  int T_SMPL   = DEF_T_SMPL,
  parameter  int T_SETTLE = DEF_T_SETTLE,
  localparam int CW       = $clog2(N_CHNL)
) (
  input  logic              clk,
  input  logic              srstz,
  input  logic              start,
  input  logic              mode_cont,
  input  logic              stop,
  input  logic              mode_cmp,
  input  logic [N_CHNL-1:0] chnl_en,
  input  logic [DAC_W-1:0]  cmp_code,
  input  logic              comp_o,
  output logic [N_CHNL-1:0] dac_sel,
  output logic              sh_rst,
  output logic              sh_hold,
  output logic [DAC_W-1:0]  dac_code,
  output logic              busy,
  output logic              res_vld,
  output logic [CW-1:0]     res_chnl,
  output logic [DAC_W-1:0]  res_code
);
  localparam int BW = $clog2(DAC_W);
  state_e            st_q;
  logic [1:0]        sync_q;
  logic [N_CHNL-1:0] en_q, above, nxt_m;
  logic [CW-1:0]     ch_q;
  logic              cmp_q, stop_pend_q, tmr_ld_q, tmr_done, comp_sync;
  logic [DAC_W-1:0]  code_q, kept;
  logic [BW-1:0]     bit_q;
  logic [TMR_W-1:0]  tmr_val_q;

  function automatic logic [CW-1:0] first_ch(input logic [N_CHNL-1:0] m);
    return CW'(onehot2idx(64'(m & (~m + N_CHNL'(1)))));
  endfunction

  sar_adc_tmr #(.W(TMR_W)) u_tmr (
    .clk    (clk),
    .srstz  (srstz),
    .ld_i   (tmr_ld_q),
    .val_i  (tmr_val_q),
    .done_o (tmr_done)
  );

  always_ff @(posedge clk or negedge srstz)
    if (!srstz) sync_q <= '0;
    else sync_q <= {sync_q[0], comp_o};

  assign comp_sync = sync_q[1];

  always_comb begin
    above = en_q & ~(((N_CHNL'(1) << ch_q) << 1) - N_CHNL'(1));
    nxt_m = |above ? above : en_q;
    kept  = comp_sync ? dac_code : dac_code & ~(DAC_W'(1) << bit_q);
  end

  always_ff @(posedge clk or negedge srstz) begin
    if (!srstz) begin
      st_q        <= S_IDLE;
      dac_sel     <= '0;
      sh_rst      <= 1'b0;
      sh_hold     <= 1'b1;
      dac_code    <= '0;
      busy        <= 1'b0;
      res_vld     <= 1'b0;
      res_chnl    <= '0;
      res_code    <= '0;
      en_q        <= '0;
      ch_q        <= '0;
      cmp_q       <= 1'b0;
      code_q      <= '0;
      bit_q       <= '0;
      stop_pend_q <= 1'b0;
      tmr_ld_q    <= 1'b0;
      tmr_val_q   <= '0;
    end else begin
      tmr_ld_q    <= 1'b0;
      res_vld     <= 1'b0;
      stop_pend_q <= (st_q != S_IDLE) && (stop_pend_q || stop);
      case (st_q)
        S_IDLE: if (start && |chnl_en) begin
          en_q      <= chnl_en;
          cmp_q     <= mode_cmp;
          code_q    <= cmp_code;
          ch_q      <= first_ch(chnl_en);
          busy      <= 1'b1;
          sh_rst    <= 1'b1;
          st_q      <= S_RST;
          tmr_ld_q  <= 1'b1;
          tmr_val_q <= TMR_W'(T_RST);
        end
        S_RST: if (tmr_done) begin
          sh_rst    <= 1'b0;
          st_q      <= S_GAP_A;
          tmr_ld_q  <= 1'b1;
          tmr_val_q <= TMR_W'(T_GAP);
        end
        S_GAP_A: if (tmr_done) begin
          dac_sel   <= N_CHNL'(1) << ch_q;
          sh_hold   <= 1'b0;
          st_q      <= S_SMPL;
          tmr_ld_q  <= 1'b1;
          tmr_val_q <= TMR_W'(T_SMPL);
        end
        S_SMPL: if (tmr_done) begin
          sh_hold   <= 1'b1;
          st_q      <= S_GAP_H;
          tmr_ld_q  <= 1'b1;
          tmr_val_q <= TMR_W'(1 + T_GAP);
        end
        // Hold is already asserted on entry, so the channel opens one cycle later.
        S_GAP_H: begin
          dac_sel <= '0;
          if (tmr_done) begin
            dac_code  <= cmp_q ? code_q : DAC_W'(1) << (DAC_W - 1);
            bit_q     <= BW'(DAC_W - 1);
            st_q      <= S_CONV;
            tmr_ld_q  <= 1'b1;
            tmr_val_q <= TMR_W'(T_SETTLE);
          end
        end
        S_CONV: if (tmr_done) begin
          if (cmp_q || bit_q == '0) begin
            res_vld  <= 1'b1;
            res_chnl <= ch_q;
            res_code <= cmp_q ? DAC_W'(comp_sync) : kept;
            dac_code <= '0;
            st_q     <= S_DONE;
          end else begin
            dac_code  <= kept | (DAC_W'(1) << (bit_q - 1'b1));
            bit_q     <= bit_q - 1'b1;
            tmr_ld_q  <= 1'b1;
            tmr_val_q <= TMR_W'(T_SETTLE);
          end
        end
        S_DONE: if (!stop_pend_q && (|above || mode_cont)) begin
          ch_q      <= first_ch(nxt_m);
          sh_rst    <= 1'b1;
          st_q      <= S_RST;
          tmr_ld_q  <= 1'b1;
          tmr_val_q <= TMR_W'(T_RST);
        end else begin
          busy <= 1'b0;
          st_q <= S_IDLE;
        end
        default: st_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sar_adc_seq.sv
// tb_sar_adc_seq: table-driven and randomized checks of sar_adc_seq against an ideal comparator model
module tb_sar_adc_seq;
  localparam int N = 14;
  localparam int T_GAP = 1;
  localparam int CH_LAT = 46;

  logic          clk = 1'b0, srstz = 1'b0, start = 1'b0, mode_cont = 1'b0, stop = 1'b0, mode_cmp = 1'b0;
  logic [N-1:0]  chnl_en = '0;
  logic [9:0]    cmp_code = '0;
  logic          comp_o;
  logic [N-1:0]  dac_sel;
  logic          sh_rst, sh_hold, busy, res_vld;
  logic [9:0]    dac_code, res_code;
  logic [3:0]    res_chnl;

  typedef struct { int ch; int code; int cyc; } res_t;
  typedef struct { logic [N-1:0] en; logic cmp; logic [9:0] cc; int v; int ech; int ecode; } vec_t;

  res_t res_q[$];
  vec_t tbl[9];
  int   v_mv[N];
  int   held_ch = 0, ncyc = 0, errors = 0, checks = 0;
  int   last_rst = -100, last_sel = -100;
  logic [N-1:0] prev_sel = '0;
  logic prev_rst = 1'b0, prev_hold = 1'b1;

  sar_adc_seq dut (
    .clk(clk), .srstz(srstz), .start(start), .mode_cont(mode_cont), .stop(stop),
    .mode_cmp(mode_cmp), .chnl_en(chnl_en), .cmp_code(cmp_code), .comp_o(comp_o),
    .dac_sel(dac_sel), .sh_rst(sh_rst), .sh_hold(sh_hold), .dac_code(dac_code),
    .busy(busy), .res_vld(res_vld), .res_chnl(res_chnl), .res_code(res_code)
  );

  always #5 clk = ~clk;

  // Ideal comparator: held capacitor voltage versus a 2 mV/LSB DAC.
  assign comp_o = v_mv[held_ch] > 2 * int'(dac_code);

  function automatic int sar_ref(input int v);
    int r = 0;
    for (int c = 0; c < 1024; c++) if (2 * c < v) r = c;
    return r;
  endfunction

  function automatic int exp_code(input int ch, input logic c, input logic [9:0] cc);
    return c ? int'(v_mv[ch] > 2 * int'(cc)) : sar_ref(v_mv[ch]);
  endfunction

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    ncyc++;
    if (res_vld) res_q.push_back('{int'(res_chnl), int'(res_code), ncyc});
    for (int i = 0; i < N; i++) if (dac_sel[i]) held_ch = i;
    if (srstz) begin
      checks += 4;
      if ((sh_rst && |dac_sel) || (sh_rst && !sh_hold) || !$onehot0(dac_sel)) begin
        errors++;
        $display("FAIL order: sh_rst=%0b sh_hold=%0b dac_sel=%h", sh_rst, sh_hold, dac_sel);
      end
      if (|dac_sel && prev_sel == '0 && (ncyc - last_rst - 1 < T_GAP || ncyc - last_sel - 1 < T_GAP)) begin
        errors++;
        $display("FAIL sel_gap: rst_gap=%0d sel_gap=%0d need %0d", ncyc - last_rst - 1, ncyc - last_sel - 1, T_GAP);
      end
      if (sh_rst && !prev_rst && ncyc - last_sel - 1 < T_GAP) begin
        errors++;
        $display("FAIL rst_gap: got %0d need %0d", ncyc - last_sel - 1, T_GAP);
      end
      if (prev_sel != '0 && dac_sel != prev_sel && (!prev_hold || dac_sel != '0)) begin
        errors++;
        $display("FAIL deselect: prev=%h now=%h prev_hold=%0b", prev_sel, dac_sel, prev_hold);
      end
    end
    if (sh_rst) last_rst = ncyc;
    if (|dac_sel) last_sel = ncyc;
    prev_sel = dac_sel;
    prev_rst = sh_rst;
    prev_hold = sh_hold;
  end

  task automatic check_reset(input string tag);
    chk({tag, "_dac_sel"}, int'(dac_sel), 0);
    chk({tag, "_sh_rst"}, int'(sh_rst), 0);
    chk({tag, "_sh_hold"}, int'(sh_hold), 1);
    chk({tag, "_dac_code"}, int'(dac_code), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_res_vld"}, int'(res_vld), 0);
    chk({tag, "_res_chnl"}, int'(res_chnl), 0);
    chk({tag, "_res_code"}, int'(res_code), 0);
  endtask

  task automatic start_scan(input logic [N-1:0] m, input logic c, input logic [9:0] cc, input logic cont);
    @(negedge clk);
    chnl_en = m; mode_cmp = c; cmp_code = cc; mode_cont = cont; start = 1'b1;
    @(negedge clk);
    start = 1'b0; chnl_en = N'($urandom); mode_cmp = ~c; cmp_code = 10'($urandom);
  endtask

  task automatic wait_res(input int n, input int budget);
    int k = 0;
    while (res_q.size() < n && k < budget) begin @(negedge clk); k++; end
    chk("res_arrived", res_q.size() >= n ? n : res_q.size(), n);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin @(negedge clk); k++; end
    chk("busy_drop", int'(busy), 0);
  endtask

  task automatic check_res(input string tag, input int ech, input int ecode);
    res_t r;
    if (res_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: got no result expected ch %0d code %0d", tag, ech, ecode);
    end else begin
      r = res_q.pop_front();
      chk({tag, "_ch"}, r.ch, ech);
      chk({tag, "_code"}, r.code, ecode);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] m;
    logic c;
    logic [9:0] cc;
    int n, seen;
    tbl[0] = '{14'h0004, 1'b0, 10'd0,   600,  2, 299};
    tbl[1] = '{14'h0004, 1'b1, 10'd250, 600,  2, 1};
    tbl[2] = '{14'h0004, 1'b1, 10'd250, 400,  2, 0};
    tbl[3] = '{14'h0001, 1'b0, 10'd0,   0,    0, 0};
    tbl[4] = '{14'h2000, 1'b0, 10'd0,   2100, 13, 1023};
    tbl[5] = '{14'h0100, 1'b0, 10'd0,   3,    8, 1};
    tbl[6] = '{14'h0010, 1'b0, 10'd0,   601,  4, 300};
    tbl[7] = '{14'h0020, 1'b1, 10'd300, 601,  5, 1};
    tbl[8] = '{14'h0020, 1'b1, 10'd300, 600,  5, 0};
    for (int i = 0; i < N; i++) v_mv[i] = 0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    srstz = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      for (int j = 0; j < N; j++) v_mv[j] = tbl[i].v;
      res_q.delete();
      start_scan(tbl[i].en, tbl[i].cmp, tbl[i].cc, 1'b0);
      wait_res(1, 100);
      wait_idle(100);
      check_res($sformatf("vec%0d", i), tbl[i].ech, tbl[i].ecode);
    end

    seen = 0;
    start_scan('0, 1'b0, 10'd0, 1'b0);
    repeat (10) begin @(negedge clk); seen += int'(busy); end
    chk("zero_mask_busy", seen, 0);

    for (int j = 0; j < N; j++) v_mv[j] = int'($urandom_range(0, 2100));
    res_q.delete();
    start_scan(14'h2001, 1'b0, 10'd0, 1'b0);
    wait_res(1, 100);
    @(negedge clk); chnl_en = 14'h0002; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_res(2, 100);
    wait_idle(100);
    seen = 0;
    repeat (60) begin @(negedge clk); seen += int'(|dac_sel); end
    chk("t2_no_sel", seen, 0);
    chk("t2_count", res_q.size(), 2);
    if (res_q.size() >= 2) chk("t2_spacing", res_q[1].cyc - res_q[0].cyc, CH_LAT);
    check_res("t2_r0", 0, sar_ref(v_mv[0]));
    check_res("t2_r1", 13, sar_ref(v_mv[13]));

    for (int j = 0; j < N; j++) v_mv[j] = int'($urandom_range(0, 2100));
    res_q.delete();
    start_scan(14'h0005, 1'b0, 10'd0, 1'b1);
    wait_res(2, 200);
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    wait_res(3, 200);
    mode_cont = 1'b0;
    wait_idle(200);
    repeat (60) @(negedge clk);
    chk("t3_count", res_q.size(), 3);
    if (res_q.size() >= 2) chk("t3_spacing", res_q[1].cyc - res_q[0].cyc, CH_LAT);
    check_res("t3_r0", 0, sar_ref(v_mv[0]));
    check_res("t3_r1", 2, sar_ref(v_mv[2]));
    check_res("t3_r2", 0, sar_ref(v_mv[0]));

    for (int j = 0; j < N; j++) v_mv[j] = 500;
    res_q.delete();
    start_scan(14'h0008, 1'b0, 10'd0, 1'b0);
    n = 0;
    while (!(busy && dac_code[5:0] == 6'b100000) && n < 200) begin @(negedge clk); n++; end
    chk("t5_reach_bit5", int'(busy && dac_code[5:0] == 6'b100000), 1);
    #2 srstz = 1'b0;
    #1 check_reset("t5");
    repeat (3) @(negedge clk);
    srstz = 1'b1;
    repeat (60) @(negedge clk);
    chk("t5_no_res", res_q.size(), 0);
    chk("t5_idle", int'(busy), 0);

    for (int k = 0; k < 6; k++) begin
      m = N'($urandom_range(1, 16383));
      c = 1'($urandom_range(0, 1));
      cc = 10'($urandom_range(0, 1023));
      for (int j = 0; j < N; j++) v_mv[j] = int'($urandom_range(0, 2100));
      n = $countones(m);
      res_q.delete();
      start_scan(m, c, cc, 1'b0);
      wait_res(n, 50 * n + 100);
      wait_idle(100);
      chk($sformatf("rnd%0d_count", k), res_q.size(), n);
      for (int j = 0; j < N; j++)
        if (m[j]) check_res($sformatf("rnd%0d_ch%0d", k, j), j, exp_code(j, c, cc));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
